// File: rtl/core_ctrl_pkg.sv
// Shared types and defaults for the core pipeline control.
package core_ctrl_pkg;

  // Branch compare operation from the s0 decoder.
  typedef enum logic [2:0] {
    CmpNull = 3'd0,
    CmpEq   = 3'd1,
    CmpNe   = 3'd2,
    CmpLt   = 3'd3,
    CmpGe   = 3'd4,
    CmpLtu  = 3'd5,
    CmpGeu  = 3'd6,
    CmpTrue = 3'd7
  } cmp_op_e;

  localparam int unsigned PcWDefault       = 30;
  localparam int unsigned McWDefault       = 22;
  localparam int unsigned IdWDefault       = 25;
  localparam int unsigned DataWDefault     = 32;
  localparam int unsigned DepBubbleDefault = 4;
  localparam int unsigned BrBubbleDefault  = 4;
  localparam int unsigned MemDelayDefault  = 4;

  // Width of a down-counter that must hold max_val; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator.
module branch_cmp
  import core_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  cmp_op_e           cmp_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              take
);

  // Evaluate the selected relation between the two operands.
  always_comb begin
    take = 1'b0;
    unique case (cmp_op)
      CmpNull: take = 1'b0;
      CmpEq:   take = (a == b);
      CmpNe:   take = (a != b);
      CmpLt:   take = ($signed(a) < $signed(b));
      CmpGe:   take = ($signed(a) >= $signed(b));
      CmpLtu:  take = (a < b);
      CmpGeu:  take = (a >= b);
      CmpTrue: take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// PC ownership, branch resolution and hazard bubble insertion for the 5-stage core.
module pipeline_hazard_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned PC_W        = PcWDefault,
  parameter int unsigned MC_W        = McWDefault,
  parameter int unsigned ID_W        = IdWDefault,
  parameter int unsigned DATA_W      = DataWDefault,
  parameter int unsigned DEP_BUBBLES = DepBubbleDefault,
  parameter int unsigned BR_BUBBLES  = BrBubbleDefault,
  parameter int unsigned MEM_DELAY   = MemDelayDefault,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_enable,
  input  logic              mem_ready,
  input  logic [MC_W-1:0]   microcode_s0,
  input  logic [ID_W-1:0]   instruction_data_si,
  input  logic [2:0]        cmp_op_s0,
  input  logic              mem_in_use_s1,
  input  logic              jump_if_branch_s2,
  input  logic              data_dep,
  input  logic [DATA_W-1:0] reg_out_a,
  input  logic [DATA_W-1:0] reg_out_b,
  input  logic [PC_W-1:0]   jmp_addr,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_s0,
  output logic [PC_W-1:0]   ret_addr,
  output logic [MC_W-1:0]   microcode_s1,
  output logic [MC_W-1:0]   microcode_s2,
  output logic [MC_W-1:0]   microcode_s3,
  output logic [ID_W-1:0]   instruction_data_s0,
  output logic [ID_W-1:0]   instruction_data_s1,
  output logic [ID_W-1:0]   instruction_data_s2,
  output logic [ID_W-1:0]   instruction_data_s3,
  output logic              blk_s0
);

  localparam int unsigned DepCntW = cnt_w(DEP_BUBBLES);
  localparam int unsigned BrCntW  = cnt_w(BR_BUBBLES);
  localparam logic [PC_W-1:0]    ResetPc  = PC_W'(RESET_PC);
  localparam logic [DepCntW-1:0] DepLoad  = DepCntW'(DEP_BUBBLES);
  localparam logic [BrCntW-1:0]  BrLoad   = BrCntW'(BR_BUBBLES);

  logic                 adv;
  logic                 take;

  logic                 branch_q;
  logic                 redirect_q;
  logic                 dep_pend_q;
  logic [BrCntW-1:0]    br_cnt_q, br_cnt_d;
  logic [DepCntW-1:0]   dep_cnt_q, dep_cnt_d;
  logic [MEM_DELAY-1:0] mem_pipe_q, mem_pipe_d;

  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W-1:0]      pc_sf_q, pc_s0_q, pc_s1_q, pc_s2_q;

  logic [MC_W-1:0]      mc_s1_q, mc_s2_q, mc_s3_q;
  logic [ID_W-1:0]      id_s0_q, id_s1_q, id_s2_q, id_s3_q;

  branch_cmp #(
    .DATA_W (DATA_W)
  ) u_branch_cmp (
    .cmp_op (cmp_op_e'(cmp_op_s0)),
    .a      (reg_out_a),
    .b      (reg_out_b),
    .take   (take)
  );

  // Advance qualifier, hazard window next-state, bubble request and PC selection.
  always_comb begin
    adv = clk_enable & mem_ready;

    // A reload to the full count is the same as OR-ing overlapping windows.
    br_cnt_d = br_cnt_q;
    if (branch_q) begin
      br_cnt_d = BrLoad;
    end else if (br_cnt_q != '0) begin
      br_cnt_d = br_cnt_q - BrCntW'(1);
    end

    dep_cnt_d = dep_cnt_q;
    if (data_dep) begin
      dep_cnt_d = DepLoad;
    end else if (dep_cnt_q != '0) begin
      dep_cnt_d = dep_cnt_q - DepCntW'(1);
    end

    mem_pipe_d    = mem_pipe_q << 1;
    mem_pipe_d[0] = mem_in_use_s1;

    blk_s0 = data_dep | (dep_cnt_q != '0) | branch_q | (br_cnt_q != '0) |
             mem_pipe_q[MEM_DELAY-1];

    pc_d = pc_q + PC_W'(1);
    if (redirect_q && jump_if_branch_s2) begin
      pc_d = jmp_addr;
    end else if (dep_pend_q) begin
      pc_d = pc_s1_q;
    end else if (mem_in_use_s1) begin
      pc_d = pc_q;
    end
  end

  // Compare result, hazard counters and the memory delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_q   <= 1'b0;
      redirect_q <= 1'b0;
      dep_pend_q <= 1'b0;
      br_cnt_q   <= '0;
      dep_cnt_q  <= '0;
      mem_pipe_q <= '0;
    end else if (adv) begin
      branch_q   <= take;
      redirect_q <= branch_q;
      dep_pend_q <= data_dep;
      br_cnt_q   <= br_cnt_d;
      dep_cnt_q  <= dep_cnt_d;
      mem_pipe_q <= mem_pipe_d;
    end
  end

  // Fetch PC and its shadow copies that follow the instruction down the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= ResetPc;
      pc_sf_q <= ResetPc;
      pc_s0_q <= ResetPc;
      pc_s1_q <= ResetPc;
      pc_s2_q <= ResetPc;
    end else if (adv) begin
      pc_q    <= pc_d;
      pc_sf_q <= pc_q;
      pc_s0_q <= pc_sf_q;
      pc_s1_q <= pc_s0_q;
      pc_s2_q <= pc_s1_q;
    end
  end

  // Microcode and instruction data stages; a bubble zeroes what enters s1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_s1_q <= '0;
      mc_s2_q <= '0;
      mc_s3_q <= '0;
      id_s0_q <= '0;
      id_s1_q <= '0;
      id_s2_q <= '0;
      id_s3_q <= '0;
    end else if (adv) begin
      id_s0_q <= instruction_data_si;
      mc_s1_q <= blk_s0 ? '0 : microcode_s0;
      id_s1_q <= blk_s0 ? '0 : id_s0_q;
      mc_s2_q <= mc_s1_q;
      id_s2_q <= id_s1_q;
      mc_s3_q <= mc_s2_q;
      id_s3_q <= id_s2_q;
    end
  end

  assign pc                  = pc_q;
  assign pc_s0               = pc_s0_q;
  assign ret_addr            = pc_s2_q;
  assign microcode_s1        = mc_s1_q;
  assign microcode_s2        = mc_s2_q;
  assign microcode_s3        = mc_s3_q;
  assign instruction_data_s0 = id_s0_q;
  assign instruction_data_s1 = id_s1_q;
  assign instruction_data_s2 = id_s2_q;
  assign instruction_data_s3 = id_s3_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes per-cycle expectations,
// a monitor on the falling edge pops and compares them.
module tb_pipeline_hazard_ctrl;

  localparam logic [21:0] Mc = 22'h2A5A5A;
  localparam logic [24:0] K1 = 25'h00ABCDE;
  localparam logic [24:0] K2 = 25'h1234567;

  typedef enum int {SPc, SPcS0, SRet, SBlk, SMc1, SMc3, SId0, SId3, SPc4} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst4_n = 1'b0;
  logic        en4 = 1'b0;
  logic        clk_enable = 1'b1;
  logic        mem_ready = 1'b1;
  logic [21:0] microcode_s0 = Mc;
  logic [24:0] instruction_data_si = K1;
  logic [2:0]  cmp_op_s0 = 3'd0;
  logic        mem_in_use_s1 = 1'b0;
  logic        jump_if_branch_s2 = 1'b0;
  logic        data_dep = 1'b0;
  logic [31:0] reg_out_a = '0;
  logic [31:0] reg_out_b = '0;
  logic [29:0] jmp_addr = '0;

  logic [29:0] pc, pc_s0, ret_addr;
  logic [21:0] microcode_s1, microcode_s2, microcode_s3;
  logic [24:0] instruction_data_s0, instruction_data_s1, instruction_data_s2;
  logic [24:0] instruction_data_s3;
  logic        blk_s0;

  logic [3:0]  pc4, pc4_s0, ret4;
  logic [21:0] mc4_s1, mc4_s2, mc4_s3;
  logic [24:0] id4_s0, id4_s1, id4_s2, id4_s3;
  logic        blk4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipeline_hazard_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .clk_enable          (clk_enable),
    .mem_ready           (mem_ready),
    .microcode_s0        (microcode_s0),
    .instruction_data_si (instruction_data_si),
    .cmp_op_s0           (cmp_op_s0),
    .mem_in_use_s1       (mem_in_use_s1),
    .jump_if_branch_s2   (jump_if_branch_s2),
    .data_dep            (data_dep),
    .reg_out_a           (reg_out_a),
    .reg_out_b           (reg_out_b),
    .jmp_addr            (jmp_addr),
    .pc                  (pc),
    .pc_s0               (pc_s0),
    .ret_addr            (ret_addr),
    .microcode_s1        (microcode_s1),
    .microcode_s2        (microcode_s2),
    .microcode_s3        (microcode_s3),
    .instruction_data_s0 (instruction_data_s0),
    .instruction_data_s1 (instruction_data_s1),
    .instruction_data_s2 (instruction_data_s2),
    .instruction_data_s3 (instruction_data_s3),
    .blk_s0              (blk_s0)
  );

  pipeline_hazard_ctrl #(
    .PC_W (4)
  ) dut4 (
    .clk                 (clk),
    .rst_n               (rst4_n),
    .clk_enable          (en4),
    .mem_ready           (1'b1),
    .microcode_s0        (22'd0),
    .instruction_data_si (25'd0),
    .cmp_op_s0           (3'd0),
    .mem_in_use_s1       (1'b0),
    .jump_if_branch_s2   (1'b0),
    .data_dep            (1'b0),
    .reg_out_a           (32'd0),
    .reg_out_b           (32'd0),
    .jmp_addr            (4'd0),
    .pc                  (pc4),
    .pc_s0               (pc4_s0),
    .ret_addr            (ret4),
    .microcode_s1        (mc4_s1),
    .microcode_s2        (mc4_s2),
    .microcode_s3        (mc4_s3),
    .instruction_data_s0 (id4_s0),
    .instruction_data_s1 (id4_s1),
    .instruction_data_s2 (id4_s2),
    .instruction_data_s3 (id4_s3),
    .blk_s0              (blk4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input sig_e s, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    logic [31:0] v;
    v = '0;
    case (s)
      SPc:     v = 32'(pc);
      SPcS0:   v = 32'(pc_s0);
      SRet:    v = 32'(ret_addr);
      SBlk:    v = 32'(blk_s0);
      SMc1:    v = 32'(microcode_s1);
      SMc3:    v = 32'(microcode_s3);
      SId0:    v = 32'(instruction_data_s0);
      SId3:    v = 32'(instruction_data_s3);
      SPc4:    v = 32'(pc4);
      default: v = 'x;
    endcase
    return v;
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    exp_t        it;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        it  = sb.pop_front();
        act = observe(it.sig);
        checks++;
        if (it.cyc == cyc && act === it.val) begin
          passes++;
        end else begin
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", it.sig.name(), cyc, it.cyc,
                   act, it.val);
        end
      end
    end
  end

  task automatic do_reset();
    step();
    rst_n             = 1'b0;
    clk_enable        = 1'b1;
    mem_ready         = 1'b1;
    cmp_op_s0         = 3'd0;
    reg_out_a         = '0;
    reg_out_b         = '0;
    mem_in_use_s1     = 1'b0;
    jump_if_branch_s2 = 1'b0;
    data_dep          = 1'b0;
    jmp_addr          = '0;
    microcode_s0      = Mc;
    instruction_data_si = K1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Branch at s0 two cycles after reset release; redirect offered at N+2.
  task automatic branch_case(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic taken, input logic [29:0] tgt);
    do_reset();
    step();
    step();
    cmp_op_s0 = op;
    reg_out_a = a;
    reg_out_b = b;
    ex(SPc, 2); ex(SBlk, 0);
    step();
    cmp_op_s0 = 3'd0;
    ex(SPc, 3); ex(SBlk, 32'(taken)); ex(SMc1, 32'(Mc));
    step();
    jump_if_branch_s2 = 1'b1;
    jmp_addr = tgt;
    ex(SPc, 4); ex(SBlk, 32'(taken)); ex(SMc1, taken ? 32'd0 : 32'(Mc));
    step();
    jump_if_branch_s2 = 1'b0;
    ex(SPc, taken ? 32'(tgt) : 32'd5); ex(SBlk, 32'(taken));
    step();
    ex(SPc, taken ? 32'(tgt) + 1 : 32'd6); ex(SBlk, 32'(taken));
    step();
    ex(SBlk, 32'(taken)); ex(SMc1, taken ? 32'd0 : 32'(Mc));
    step();
    ex(SBlk, 0); ex(SMc1, taken ? 32'd0 : 32'(Mc));
    step();
    ex(SMc1, 32'(Mc));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t it;
    step();
    rst4_n = 1'b1;

    // Plain sequential fetch after reset.
    do_reset();
    ex(SPc, 0); ex(SBlk, 0); ex(SPcS0, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      ex(SPc, 32'(k)); ex(SPcS0, (k >= 2) ? 32'(k - 2) : 32'd0); ex(SBlk, 0);
      if (k == 3) ex(SMc3, 32'(Mc));
      if (k == 4) ex(SId3, 32'(K1));
      if (k == 6) ex(SRet, 2);
    end

    // Compare operations: taken and untaken.
    branch_case(3'd1, 32'd5, 32'd5, 1'b1, 30'h100);
    branch_case(3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 30'h200);
    branch_case(3'd6, 32'hFFFF_FFFF, 32'd1, 1'b1, 30'h200);
    branch_case(3'd3, 32'hFFFF_FFFF, 32'd1, 1'b1, 30'h300);
    branch_case(3'd5, 32'hFFFF_FFFF, 32'd1, 1'b0, 30'h300);

    // Data dependency refetch with a second overlapping pulse.
    do_reset();
    for (int k = 0; k < 34; k++) step();
    data_dep = 1'b1;
    ex(SPc, 32'h22); ex(SBlk, 1);
    step();
    data_dep = 1'b0;
    ex(SPc, 32'h23); ex(SBlk, 1);
    step();
    data_dep = 1'b1;
    ex(SPc, 32'h20); ex(SBlk, 1);
    step();
    data_dep = 1'b0;
    ex(SPc, 32'h21); ex(SBlk, 1);
    step();
    ex(SPc, 32'h22); ex(SBlk, 1);
    step(); ex(SBlk, 1);
    step(); ex(SBlk, 1);
    step(); ex(SBlk, 0);

    // Memory in use: PC hold now, s0 block MEM_DELAY cycles later.
    do_reset();
    step();
    step();
    mem_in_use_s1 = 1'b1;
    ex(SPc, 2); ex(SBlk, 0);
    step();
    mem_in_use_s1 = 1'b0;
    ex(SPc, 2); ex(SBlk, 0);
    step(); ex(SPc, 3); ex(SBlk, 0);
    step(); ex(SBlk, 0);
    step(); ex(SBlk, 1);
    step(); ex(SBlk, 0);

    // mem_ready low for three cycles inside a branch window.
    do_reset();
    step();
    step();
    cmp_op_s0 = 3'd1;
    reg_out_a = 32'd5;
    reg_out_b = 32'd5;
    ex(SPc, 2);
    step();
    cmp_op_s0 = 3'd0;
    ex(SPc, 3); ex(SBlk, 1);
    step();
    mem_ready = 1'b0;
    instruction_data_si = K2;
    ex(SPc, 4); ex(SBlk, 1); ex(SId0, 32'(K1)); ex(SMc1, 0);
    step();
    ex(SPc, 4); ex(SBlk, 1); ex(SId0, 32'(K1)); ex(SMc1, 0);
    step();
    ex(SPc, 4); ex(SBlk, 1); ex(SId0, 32'(K1)); ex(SMc1, 0);
    step();
    mem_ready = 1'b1;
    ex(SPc, 4); ex(SBlk, 1); ex(SId0, 32'(K1));
    step(); ex(SPc, 5); ex(SBlk, 1); ex(SId0, 32'(K2));
    step(); ex(SBlk, 1);
    step(); ex(SBlk, 1);
    step(); ex(SBlk, 0);

    // Asynchronous reset while a redirect is pending.
    do_reset();
    step();
    step();
    cmp_op_s0 = 3'd1;
    reg_out_a = 32'd5;
    reg_out_b = 32'd5;
    step();
    cmp_op_s0 = 3'd0;
    step();
    jump_if_branch_s2 = 1'b1;
    jmp_addr = 30'h100;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc === 30'd0) begin
      passes++;
    end else begin
      $display("FAIL async reset pc got=%h exp=0", pc);
    end
    checks++;
    if (blk_s0 === 1'b0) begin
      passes++;
    end else begin
      $display("FAIL async reset blk_s0 got=%b exp=0", blk_s0);
    end
    ex(SPc, 0); ex(SBlk, 0); ex(SMc1, 0);
    step();
    rst_n = 1'b1;
    ex(SPc, 0); ex(SBlk, 0);
    step();
    jump_if_branch_s2 = 1'b0;
    ex(SPc, 1); ex(SBlk, 0);

    // 4-bit PC wraps from 15 to 0.
    en4 = 1'b1;
    ex(SPc4, 0);
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k >= 14) ex(SPc4, 32'(k % 16));
    end
    en4 = 1'b0;

    step();
    step();
    while (sb.size() > 0) begin
      it = sb.pop_front();
      checks++;
      $display("FAIL %s unchecked due=%0d exp=%h", it.sig.name(), it.cyc, it.val);
    end
    if (passes != checks || checks < 12) begin
      $display("FAIL summary passes=%0d checks=%0d", passes, checks);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
